// File: rtl/sound_fx_pkg.sv
// ---------------------------------------------------------------------------
// sound_fx_pkg
//   Shared definitions for the sound effect generator:
//     - tone_id encodings (TONE_NONE, TONE_WALL, TONE_HIT, TONE_GOAL)
//     - FSM state encodings (IDLE, TONE1, GAP, TONE2, and JING0..JING2 when
//       the win jingle is built in via SOUND_FX_WIN_JINGLE_EN)
//     - event_tone(): maps simultaneous event pulses onto the single
//       highest-priority tone (goal > hit > wall).
//   Optional feature macro: SOUND_FX_WIN_JINGLE_EN
// ---------------------------------------------------------------------------
package sound_fx_pkg;

  // The tone_id value doubles as the priority of the effect, so a plain
  // unsigned compare decides whether an event may retrigger.
  localparam logic [1:0] TONE_NONE = 2'b00;
  localparam logic [1:0] TONE_WALL = 2'b01;
  localparam logic [1:0] TONE_HIT  = 2'b10;
  localparam logic [1:0] TONE_GOAL = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    TONE1 = 3'd1,
    GAP   = 3'd2,
    TONE2 = 3'd3
`ifdef SOUND_FX_WIN_JINGLE_EN
    ,
    JING0 = 3'd4,
    JING1 = 3'd5,
    JING2 = 3'd6
`endif
  } state_e;

  // Lower-priority pulses arriving on the same cycle are dropped here.
  function automatic logic [1:0] event_tone(input logic hit,
                                            input logic wall,
                                            input logic goal);
    if (goal)      return TONE_GOAL;
    else if (hit)  return TONE_HIT;
    else if (wall) return TONE_WALL;
    return TONE_NONE;
  endfunction

endpackage

// File: rtl/sound_fx_tone_osc.sv
// ---------------------------------------------------------------------------
// tone_osc
//   Square-wave generator: a half-period counter plus a toggle flip-flop.
//   Ports:
//     clk   in   system clock
//     rst   in   asynchronous active-high reset
//     en    in   count while high; counter and wave hold while low
//     clr   in   synchronous clear of counter and wave (wins over en)
//     half  in   half-period in clk cycles (must be >= 1)
//     wave  out  square wave, starts low after a clear
// ---------------------------------------------------------------------------
module tone_osc
  import sound_fx_pkg::*;
#(
  parameter int CW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic [CW-1:0] half,
  output logic          wave
);

  logic [CW-1:0] cnt;
  logic          cnt_last;

  assign cnt_last = (cnt == (half - 1'b1));

  // The counter runs 0..half-1; on its last value the wave flips and the
  // counter folds back to 0, so it never reaches a wrapping value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      wave <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      wave <= 1'b0;
    end else if (en) begin
      if (cnt_last) begin
        cnt  <= '0;
        wave <= ~wave;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sound_fx.sv
// ---------------------------------------------------------------------------
// sound_fx
//   Turns single-cycle game events into timed square-wave sound effects with
//   a priority / retrigger policy.
//   Ports:
//     clk      in   system clock
//     rst      in   asynchronous active-high reset
//     hit      in   paddle-collision pulse (one cycle)
//     wall     in   wall-collision pulse (one cycle)
//     goal     in   goal pulse (one cycle)
//     mute     in   level; forces spk low without disturbing the effect
//     p1_win   in   (SOUND_FX_WIN_JINGLE_EN only) player 1 win level
//     p2_win   in   (SOUND_FX_WIN_JINGLE_EN only) player 2 win level
//     spk      out  square-wave speaker drive
//     busy     out  high while any effect (including the goal gap) runs
//     tone_id  out  00 none, 01 wall, 10 hit, 11 goal / jingle
//   Optional feature macro: SOUND_FX_WIN_JINGLE_EN adds a three-note win
//   jingle with top priority, started by a rising edge of p1_win|p2_win.
// ---------------------------------------------------------------------------
module sound_fx
  import sound_fx_pkg::*;
#(
  parameter int HIT_HALF    = 28409,
  parameter int WALL_HALF   = 56818,
  parameter int GOAL_HALF_A = 18939,
  parameter int GOAL_HALF_B = 37878,
  parameter int DUR_SHORT   = 1250000,
  parameter int DUR_GOAL    = 5000000,
  parameter int DUR_GAP     = 1250000,
  parameter int CW          = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hit,
  input  logic       wall,
  input  logic       goal,
  input  logic       mute,
`ifdef SOUND_FX_WIN_JINGLE_EN
  input  logic       p1_win,
  input  logic       p2_win,
`endif
  output logic       spk,
  output logic       busy,
  output logic [1:0] tone_id
);

  localparam logic [CW-1:0] HIT_H   = CW'(HIT_HALF);
  localparam logic [CW-1:0] WALL_H  = CW'(WALL_HALF);
  localparam logic [CW-1:0] GOAL_HA = CW'(GOAL_HALF_A);
  localparam logic [CW-1:0] GOAL_HB = CW'(GOAL_HALF_B);
  localparam logic [CW-1:0] D_SHORT = CW'(DUR_SHORT);
  localparam logic [CW-1:0] D_GOAL  = CW'(DUR_GOAL);
  localparam logic [CW-1:0] D_GAP   = CW'(DUR_GAP);

  state_e        state;
  state_e        state_next;
  logic [1:0]    tone_q;
  logic [1:0]    tone_next;
  logic          busy_q;
  logic [CW-1:0] dur_cnt;
  logic [CW-1:0] dur_limit;
  logic          dur_last;
  logic          ending;
  logic          accept;
  logic          restart;
  logic [1:0]    ev_tone;
  logic [CW-1:0] half;
  logic          osc_en;
  logic          wave;

`ifdef SOUND_FX_WIN_JINGLE_EN
  logic win_prev;
  logic win_rise;
  logic jing_active;

  // Registered copy of the win level so only its rising edge starts a jingle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_prev <= 1'b0;
    end else begin
      win_prev <= p1_win | p2_win;
    end
  end

  assign win_rise    = (p1_win | p2_win) & ~win_prev;
  assign jing_active = (state == JING0) || (state == JING1) || (state == JING2);
`endif

  assign ev_tone = event_tone(hit, wall, goal);

  // Length of the segment currently playing; hit/wall are short, every goal
  // and jingle note is long, and the goal gap has its own length.
  always_comb begin
    dur_limit = D_GOAL;
    case (state)
      TONE1:   dur_limit = (tone_q == TONE_GOAL) ? D_GOAL : D_SHORT;
      GAP:     dur_limit = D_GAP;
      default: dur_limit = D_GOAL;
    endcase
  end

  assign dur_last = (state != IDLE) && (dur_cnt == (dur_limit - 1'b1));

  // Half-period steering for the single oscillator instance.
  always_comb begin
    half = HIT_H;
    case (state)
      TONE1: begin
        if (tone_q == TONE_GOAL)     half = GOAL_HA;
        else if (tone_q == TONE_HIT) half = HIT_H;
        else                         half = WALL_H;
      end
      TONE2: half = GOAL_HB;
`ifdef SOUND_FX_WIN_JINGLE_EN
      JING0: half = WALL_H;
      JING1: half = HIT_H;
      JING2: half = GOAL_HA;
`endif
      default: half = HIT_H;
    endcase
  end

  // The oscillator only runs in audible states; in IDLE and GAP it sits
  // cleared so the speaker is guaranteed low there.
  assign osc_en = (state != IDLE) && (state != GAP);

  // Next-state logic. A segment's last duration cycle advances the effect;
  // an accepted event (or jingle start) overrides that and restarts from the
  // first note. On the very last cycle of an effect any event is accepted,
  // so a back-to-back effect starts without an idle cycle in between.
  always_comb begin
    state_next = state;
    tone_next  = tone_q;
    restart    = 1'b0;
    ending     = 1'b0;

    case (state)
      IDLE: begin
        state_next = IDLE;
      end
      TONE1: begin
        if (dur_last) begin
          restart = 1'b1;
          if (tone_q == TONE_GOAL) begin
            state_next = GAP;
          end else begin
            ending     = 1'b1;
            state_next = IDLE;
            tone_next  = TONE_NONE;
          end
        end
      end
      GAP: begin
        if (dur_last) begin
          restart    = 1'b1;
          state_next = TONE2;
        end
      end
      TONE2: begin
        if (dur_last) begin
          restart    = 1'b1;
          ending     = 1'b1;
          state_next = IDLE;
          tone_next  = TONE_NONE;
        end
      end
`ifdef SOUND_FX_WIN_JINGLE_EN
      JING0: begin
        if (dur_last) begin
          restart    = 1'b1;
          state_next = JING1;
        end
      end
      JING1: begin
        if (dur_last) begin
          restart    = 1'b1;
          state_next = JING2;
        end
      end
      JING2: begin
        if (dur_last) begin
          restart    = 1'b1;
          ending     = 1'b1;
          state_next = IDLE;
          tone_next  = TONE_NONE;
        end
      end
`endif
      default: begin
        restart    = 1'b1;
        state_next = IDLE;
        tone_next  = TONE_NONE;
      end
    endcase

`ifdef SOUND_FX_WIN_JINGLE_EN
    accept = (ev_tone != TONE_NONE) &&
             (ending || (!jing_active && (ev_tone >= tone_q)));
`else
    accept = (ev_tone != TONE_NONE) && (ending || (ev_tone >= tone_q));
`endif

    if (accept) begin
      state_next = TONE1;
      tone_next  = ev_tone;
      restart    = 1'b1;
    end

`ifdef SOUND_FX_WIN_JINGLE_EN
    if (win_rise) begin
      state_next = JING0;
      tone_next  = TONE_GOAL;
      restart    = 1'b1;
    end
`endif
  end

  // State, tone and busy registers; busy is registered from the next state
  // so it changes on the same edge as tone_id.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      tone_q <= TONE_NONE;
      busy_q <= 1'b0;
    end else begin
      state  <= state_next;
      tone_q <= tone_next;
      busy_q <= (state_next != IDLE);
    end
  end

  // Duration counter: cleared on every segment change or restart, so it
  // tops out at the segment length minus one and never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dur_cnt <= '0;
    end else if (restart) begin
      dur_cnt <= '0;
    end else if (state != IDLE) begin
      dur_cnt <= dur_cnt + 1'b1;
    end
  end

  tone_osc #(
    .CW(CW)
  ) u_osc (
    .clk (clk),
    .rst (rst),
    .en  (osc_en),
    .clr (restart),
    .half(half),
    .wave(wave)
  );

  // Mute only gates the pin; the oscillator keeps its phase underneath.
  assign spk     = wave & ~mute;
  assign busy    = busy_q;
  assign tone_id = tone_q;

endmodule
